// File: rtl/hazard_scoreboard.sv
// Register-scoreboard hazard detector for an in-order pipeline: tracks in-flight writes
// per register, stalls ID on RAW or counter-overflow hazards, and counts stall cycles.
module hazard_scoreboard #(
  parameter int WIDTH  = 5,
  parameter int CNTW   = 2,
  parameter int STALLW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidID,
  input  logic [WIDTH-1:0]  Rs1ID,
  input  logic [WIDTH-1:0]  Rs2ID,
  input  logic [WIDTH-1:0]  RdID,
  input  logic              RegWriteID,
  input  logic              FlushID,
  input  logic [WIDTH-1:0]  WriteRegWB,
  input  logic              RegWriteW,
  output logic              IDStall,
  output logic              IssueID,
  output logic              Stalling,
  output logic [STALLW-1:0] StallCycles,
  output logic              WbUnderflow
);

  localparam int NREG = 2 ** WIDTH;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNTW-1:0]   r_pending [NREG];
  logic [STALLW-1:0] r_stall_cycles;
  logic              r_wb_underflow;

  logic [CNTW-1:0] w_p_rs1;
  logic [CNTW-1:0] w_p_rs2;
  logic [CNTW-1:0] w_p_rd;
  logic [CNTW-1:0] w_p_wb;
  logic            w_raw;
  logic            w_ovf;
  logic            w_inc;
  logic            w_dec;

  // Hazards look only at registered counts, so a writeback in the same cycle does not
  // release the stall until the following cycle.
  assign w_p_rs1 = r_pending[Rs1ID];
  assign w_p_rs2 = r_pending[Rs2ID];
  assign w_p_rd  = r_pending[RdID];
  assign w_p_wb  = r_pending[WriteRegWB];

  assign w_raw = ValidID && (((Rs1ID != '0) && (w_p_rs1 != '0)) ||
                             ((Rs2ID != '0) && (w_p_rs2 != '0)));
  assign w_ovf = ValidID && RegWriteID && (RdID != '0) && (w_p_rd == {CNTW{1'b1}});

  // Handshake: ValidID offers an instruction; IssueID is the acceptance, and it is
  // withheld by IDStall (hazard) or FlushID (squash). Both are forced low under reset.
  assign IDStall = !rst && (w_raw || w_ovf) && !FlushID;
  assign IssueID = !rst && ValidID && !IDStall && !FlushID;

  assign w_inc = IssueID && RegWriteID && (RdID != '0);
  assign w_dec = RegWriteW && (WriteRegWB != '0);

  // Entry 0 is written only by reset, so x0 always reads as "nothing pending".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_pending[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_inc && (RdID == WIDTH'(i)) && !(w_dec && (WriteRegWB == WIDTH'(i)))) begin
          r_pending[i] <= r_pending[i] + CNTW'(1);
        end else if (w_dec && (WriteRegWB == WIDTH'(i)) && !(w_inc && (RdID == WIDTH'(i)))
                     && (r_pending[i] != '0)) begin
          r_pending[i] <= r_pending[i] - CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_stall_cycles <= '0;
      r_wb_underflow <= 1'b0;
    end else begin
      if (w_dec && (w_p_wb == '0)) r_wb_underflow <= 1'b1;
      if (IDStall && (r_stall_cycles != {STALLW{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + STALLW'(1);
      end
      case (r_state)
        S_RUN:   if (IDStall)  r_state <= S_STALL;
        S_STALL: if (!IDStall) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign Stalling    = (r_state == S_STALL);
  assign StallCycles = r_stall_cycles;
  assign WbUnderflow = r_wb_underflow;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a cycle-by-cycle vector table plus hand-written
// reset sequences; a second instance with a 3-bit stall counter covers saturation.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        ValidID;
  logic [4:0]  Rs1ID;
  logic [4:0]  Rs2ID;
  logic [4:0]  RdID;
  logic        RegWriteID;
  logic        FlushID;
  logic [4:0]  WriteRegWB;
  logic        RegWriteW;
  logic        IDStall;
  logic        IssueID;
  logic        Stalling;
  logic [15:0] StallCycles;
  logic        WbUnderflow;
  logic        IDStall2;
  logic        IssueID2;
  logic        Stalling2;
  logic [2:0]  StallCycles2;
  logic        WbUnderflow2;

  int n_cmp;
  int n_bad;

  hazard_scoreboard #(.WIDTH(5), .CNTW(2), .STALLW(16)) u_dut (
    .clk(clk), .rst(rst), .ValidID(ValidID), .Rs1ID(Rs1ID), .Rs2ID(Rs2ID), .RdID(RdID),
    .RegWriteID(RegWriteID), .FlushID(FlushID), .WriteRegWB(WriteRegWB),
    .RegWriteW(RegWriteW), .IDStall(IDStall), .IssueID(IssueID), .Stalling(Stalling),
    .StallCycles(StallCycles), .WbUnderflow(WbUnderflow)
  );

  hazard_scoreboard #(.WIDTH(5), .CNTW(2), .STALLW(3)) u_dut_sat (
    .clk(clk), .rst(rst), .ValidID(ValidID), .Rs1ID(Rs1ID), .Rs2ID(Rs2ID), .RdID(RdID),
    .RegWriteID(RegWriteID), .FlushID(FlushID), .WriteRegWB(WriteRegWB),
    .RegWriteW(RegWriteW), .IDStall(IDStall2), .IssueID(IssueID2), .Stalling(Stalling2),
    .StallCycles(StallCycles2), .WbUnderflow(WbUnderflow2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       fl;
    logic [4:0] wbr;
    logic       wbw;
    logic       e_stall;
    logic       e_issue;
    logic       e_stalling;
    int         e_cyc;
    logic       e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                              input logic rw, input logic fl, input int wbr, input logic wbw,
                              input logic es, input logic ei, input logic eg, input int ec,
                              input logic eu);
    vec_t t;
    t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd); t.rw = rw; t.fl = fl;
    t.wbr = 5'(wbr); t.wbw = wbw;
    t.e_stall = es; t.e_issue = ei; t.e_stalling = eg; t.e_cyc = ec; t.e_unf = eu;
    return t;
  endfunction

  // Driver
  task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                       input logic rw, input logic fl, input int wbr, input logic wbw);
    ValidID = v; Rs1ID = 5'(rs1); Rs2ID = 5'(rs2); RdID = 5'(rd);
    RegWriteID = rw; FlushID = fl; WriteRegWB = 5'(wbr); RegWriteW = wbw;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic es, input logic ei, input logic eg,
                         input int ec, input logic eu);
    int sat;
    sat = (ec > 7) ? 7 : ec;
    chk({tag, ".IDStall"},     32'(IDStall),      32'(es));
    chk({tag, ".IssueID"},     32'(IssueID),      32'(ei));
    chk({tag, ".Stalling"},    32'(Stalling),     32'(eg));
    chk({tag, ".StallCycles"}, 32'(StallCycles),  32'(ec));
    chk({tag, ".WbUnderflow"}, 32'(WbUnderflow),  32'(eu));
    chk({tag, ".StallSat"},    32'(StallCycles2), 32'(sat));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //        v rs1 rs2 rd rw fl wbr wbw | stall issue stalling cyc unf
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, 0)); // idle
    vecs.push_back(mk(1, 0, 0, 5, 1, 0,  0, 0,  0, 1, 0,  0, 0)); // issue x5
    vecs.push_back(mk(1, 5, 0, 0, 0, 0,  0, 0,  1, 0, 0,  0, 0)); // RAW on x5
    vecs.push_back(mk(1, 5, 0, 0, 0, 0,  5, 1,  1, 0, 1,  1, 0)); // WB x5, no write-through
    vecs.push_back(mk(1, 5, 0, 0, 0, 0,  0, 0,  0, 1, 1,  2, 0)); // released
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0, 1,  0, 1, 0,  2, 0)); // x0 issue + WB x0
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0, 0,  0, 1, 0,  2, 0)); // x0 never overflows
    vecs.push_back(mk(1, 0, 0, 7, 1, 0,  0, 0,  0, 1, 0,  2, 0)); // x7 -> 1
    vecs.push_back(mk(1, 0, 0, 7, 1, 0,  0, 0,  0, 1, 0,  2, 0)); // x7 -> 2
    vecs.push_back(mk(1, 0, 0, 7, 1, 0,  0, 0,  0, 1, 0,  2, 0)); // x7 -> 3
    vecs.push_back(mk(1, 0, 0, 7, 1, 0,  0, 0,  1, 0, 0,  2, 0)); // overflow stall
    vecs.push_back(mk(1, 0, 0, 7, 1, 0,  7, 1,  1, 0, 1,  3, 0)); // WB x7 -> 2
    vecs.push_back(mk(1, 0, 0, 7, 1, 0,  0, 0,  0, 1, 1,  4, 0)); // fourth issues -> 3
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  7, 1,  0, 0, 0,  4, 0)); // drain x7 -> 2
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  7, 1,  0, 0, 0,  4, 0)); // drain x7 -> 1
    vecs.push_back(mk(1, 7, 0, 0, 0, 0,  7, 1,  1, 0, 0,  4, 0)); // still pending, -> 0
    vecs.push_back(mk(1, 7, 0, 0, 0, 0,  0, 0,  0, 1, 1,  5, 0)); // x7 clear
    vecs.push_back(mk(1, 0, 0, 9, 1, 0,  0, 0,  0, 1, 0,  5, 0)); // x9 -> 1
    vecs.push_back(mk(1, 0, 0, 9, 1, 0,  9, 1,  0, 1, 0,  5, 0)); // inc+dec x9 stays 1
    vecs.push_back(mk(1, 9, 0, 0, 0, 0,  0, 0,  1, 0, 0,  5, 0)); // x9 still pending
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  9, 1,  0, 0, 1,  6, 0)); // x9 -> 0
    vecs.push_back(mk(1, 9, 0, 0, 0, 0,  0, 0,  0, 1, 0,  6, 0)); // x9 was exactly 1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 12, 1,  0, 0, 0,  6, 0)); // WB x12 underflow
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  6, 1)); // sticky
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  6, 1)); // sticky
    vecs.push_back(mk(1, 0, 0, 3, 1, 0,  0, 0,  0, 1, 0,  6, 1)); // x3 -> 1
    vecs.push_back(mk(1, 0, 3, 0, 0, 0,  0, 0,  1, 0, 0,  6, 1)); // hazard cycle 1
    vecs.push_back(mk(1, 0, 3, 0, 0, 0,  0, 0,  1, 0, 1,  7, 1)); // hazard cycle 2
    vecs.push_back(mk(1, 0, 3, 0, 0, 0,  0, 0,  1, 0, 1,  8, 1)); // hazard cycle 3
    vecs.push_back(mk(1, 0, 3, 0, 0, 0,  0, 0,  1, 0, 1,  9, 1)); // hazard cycle 4
    vecs.push_back(mk(1, 0, 3, 0, 0, 1,  0, 0,  0, 0, 1, 10, 1)); // flush hides hazard
    vecs.push_back(mk(1, 0, 3, 0, 0, 1,  3, 1,  0, 0, 0, 10, 1)); // WB applies under flush
    vecs.push_back(mk(1, 0, 3, 0, 0, 0,  0, 0,  0, 1, 0, 10, 1)); // x3 cleared
    vecs.push_back(mk(1, 0, 0, 4, 1, 1,  0, 0,  0, 0, 0, 10, 1)); // flushed write to x4
    vecs.push_back(mk(1, 4, 0, 0, 0, 0,  0, 0,  0, 1, 0, 10, 1)); // x4 never counted

    // Reset with an issuable instruction present: nothing may issue.
    rst = 1'b1;
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].fl,
            vecs[i].wbr, vecs[i].wbw);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vecs[i].e_stall, vecs[i].e_issue, vecs[i].e_stalling,
              vecs[i].e_cyc, vecs[i].e_unf);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a stall with x3 pending twice.
    drive(1, 0, 0, 3, 1, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst.pre_stall", 32'(IDStall), 32'd1);
    @(posedge clk); #1;
    chk("midrst.pre_stalling", 32'(Stalling), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("midrst.async", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 3, 0, 3, 1, 0, 0, 0);
    @(negedge clk);
    chk_all("postrst.no_stall", 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("postrst.first_edge_issue", 32'(IDStall), 32'd1);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
